rdma_host_frame_mux: RTL and testbench

Multi-channel host-request frame multiplexer for the RDMA RC datapath. Merges `NUM_CH` independent host request streams (valid/data/last, now with ready backpressure) into one registered output stream. Frames are never interleaved, channels get round-robin fairness, and over-length frames are truncated. A per-frame completion pulse reports channel, beat count and error, generalising the single-bit `comp_valid`.

---
 rtl/rdma_host_frame_mux_pkg.sv | 28 ++
 rtl/rdma_host_frame_mux_if.sv | 37 +++
 rtl/rdma_host_frame_mux_rr_arbiter.sv | 60 ++++++
 rtl/rdma_host_frame_mux.sv | 192 +++++++++++++++++++
 tb/tb_rdma_host_frame_mux.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rdma_host_frame_mux_pkg.sv
// Shared types and width helpers for the RDMA host frame multiplexer.
package rdma_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    DRAIN = 2'd2
  } mux_state_e;

  // Widest channel index (16 channels) and beat count (MAX_BEATS up to 65536).
  localparam int COMP_CH_MAX_W  = 4;
  localparam int COMP_CNT_MAX_W = 17;

  typedef struct packed {
    logic [COMP_CH_MAX_W-1:0]  ch;
    logic [COMP_CNT_MAX_W-1:0] beats;
    logic                      err;
  } comp_t;

  function automatic int ch_w_f(input int num_ch);
    return (num_ch > 1) ? $clog2(num_ch) : 1;
  endfunction

  function automatic int cnt_w_f(input int max_beats);
    return $clog2(max_beats + 1);
  endfunction

endpackage

// File: rtl/rdma_host_frame_mux_if.sv
// Host-side request streams, merged output stream and completion report.
interface rdma_host_frame_mux_if #(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 256,
  parameter int CH_W      = rdma_mux_pkg::ch_w_f(NUM_CH),
  parameter int CNT_W     = rdma_mux_pkg::cnt_w_f(MAX_BEATS)
) ();
  import rdma_mux_pkg::*;

  logic [NUM_CH-1:0]        host_valid;
  logic [NUM_CH*DATA_W-1:0] host_data;
  logic [NUM_CH-1:0]        host_last;
  logic [NUM_CH-1:0]        host_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_data;
  logic                     out_last;
  logic [CH_W-1:0]          out_ch;
  logic                     out_ready;
  logic                     comp_valid;
  logic [CH_W-1:0]          comp_ch;
  logic [CNT_W-1:0]         comp_beats;
  logic                     comp_err;

  modport slave (
    input  host_valid, host_data, host_last, out_ready,
    output host_ready, out_valid, out_data, out_last, out_ch,
    output comp_valid, comp_ch, comp_beats, comp_err
  );

  modport master (
    output host_valid, host_data, host_last, out_ready,
    input  host_ready, out_valid, out_data, out_last, out_ch,
    input  comp_valid, comp_ch, comp_beats, comp_err
  );

endinterface

// File: rtl/rdma_host_frame_mux_rr_arbiter.sv
// Round-robin arbiter: priority starts one past the most recently granted channel.
module rdma_rr_arbiter
  import rdma_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int CH_W   = rdma_mux_pkg::ch_w_f(NUM_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] req_i,
  input  logic              advance_i,
  output logic [NUM_CH-1:0] gnt_oh_o,
  output logic [CH_W-1:0]   gnt_idx_o
);

  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   ptr_d;
  logic [CH_W-1:0]   gnt_idx_s;
  logic [CH_W-1:0]   idx_v;
  logic [NUM_CH-1:0] gnt_oh_s;
  logic              found_s;

  // Scan channels starting at the pointer and take the first requester.
  always_comb begin
    gnt_idx_s = '0;
    gnt_oh_s  = '0;
    found_s   = 1'b0;
    idx_v     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx_v = CH_W'((int'(ptr_q) + i) % NUM_CH);
      if (!found_s && req_i[idx_v]) begin
        found_s         = 1'b1;
        gnt_idx_s       = idx_v;
        gnt_oh_s[idx_v] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    if (advance_i && found_s) begin
      ptr_d = (gnt_idx_s == CH_W'(NUM_CH - 1)) ? '0 : gnt_idx_s + CH_W'(1);
    end else begin
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign gnt_oh_o  = gnt_oh_s;
  assign gnt_idx_o = gnt_idx_s;

endmodule

// File: rtl/rdma_host_frame_mux.sv
// Merges NUM_CH host request streams into one registered stream, frame by frame,
// truncating over-length frames and reporting a completion per delivered frame.
module rdma_host_frame_mux
  import rdma_mux_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 256,
  parameter int CH_W      = rdma_mux_pkg::ch_w_f(NUM_CH),
  parameter int CNT_W     = rdma_mux_pkg::cnt_w_f(MAX_BEATS)
) (
  input logic                  clk,
  input logic                  rst,
  rdma_host_frame_mux_if.slave bus
);

  mux_state_e        state_q, state_d;
  logic [CH_W-1:0]   gnt_q, gnt_d;
  logic [NUM_CH-1:0] gnt_oh_q, gnt_oh_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic [CH_W-1:0]   out_ch_q, out_ch_d;
  logic [CNT_W-1:0]  out_beats_q, out_beats_d;
  logic              out_err_q, out_err_d;

  logic              comp_valid_q, comp_valid_d;
  comp_t             comp_q, comp_d;

  logic [NUM_CH-1:0] arb_oh_s;
  logic [CH_W-1:0]   arb_idx_s;
  logic              advance_s;
  logic              sel_valid_s;
  logic              sel_last_s;
  logic [DATA_W-1:0] sel_data_s;
  logic              slot_free_s;
  logic              ready_en_s;
  logic              out_fire_s;
  logic [CNT_W-1:0]  cnt_next_s;
  logic              trunc_s;
  logic              unused_comp_s;

  assign advance_s   = (state_q == IDLE) && (|bus.host_valid);
  assign sel_valid_s = |(bus.host_valid & gnt_oh_q);
  assign sel_last_s  = |(bus.host_last & gnt_oh_q);
  assign slot_free_s = !out_valid_q || bus.out_ready;
  assign out_fire_s  = out_valid_q && bus.out_ready;
  assign cnt_next_s  = cnt_q + CNT_W'(1);
  assign trunc_s     = (cnt_next_s == CNT_W'(MAX_BEATS)) && !sel_last_s;

  rdma_rr_arbiter #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req_i     (bus.host_valid),
    .advance_i (advance_s),
    .gnt_oh_o  (arb_oh_s),
    .gnt_idx_o (arb_idx_s)
  );

  // AND-OR select of the granted channel's data.
  always_comb begin
    sel_data_s = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      sel_data_s = sel_data_s | (bus.host_data[i*DATA_W +: DATA_W] & {DATA_W{gnt_oh_q[i]}});
    end
  end

  // DRAIN swallows the tail of a truncated frame regardless of downstream stalls.
  always_comb begin
    case (state_q)
      BUSY:    ready_en_s = slot_free_s;
      DRAIN:   ready_en_s = 1'b1;
      default: ready_en_s = 1'b0;
    endcase
  end

  // Frame FSM, beat counter, output slice and completion next-state.
  always_comb begin
    state_d      = state_q;
    gnt_d        = gnt_q;
    gnt_oh_d     = gnt_oh_q;
    cnt_d        = cnt_q;
    out_valid_d  = out_fire_s ? 1'b0 : out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    out_ch_d     = out_ch_q;
    out_beats_d  = out_beats_q;
    out_err_d    = out_err_q;
    comp_valid_d = 1'b0;
    comp_d       = comp_q;

    case (state_q)
      IDLE: begin
        if (advance_s) begin
          state_d  = BUSY;
          gnt_d    = arb_idx_s;
          gnt_oh_d = arb_oh_s;
          cnt_d    = '0;
        end else begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (sel_valid_s && slot_free_s) begin
          cnt_d       = cnt_next_s;
          out_valid_d = 1'b1;
          out_data_d  = sel_data_s;
          out_last_d  = sel_last_s || trunc_s;
          out_ch_d    = gnt_q;
          out_beats_d = cnt_next_s;
          out_err_d   = trunc_s;
          if (sel_last_s) begin
            state_d = IDLE;
          end else if (trunc_s) begin
            state_d = DRAIN;
          end else begin
            state_d = BUSY;
          end
        end else begin
          state_d = BUSY;
        end
      end
      DRAIN: begin
        if (sel_valid_s && sel_last_s) begin
          state_d = IDLE;
        end else begin
          state_d = DRAIN;
        end
      end
      default: state_d = IDLE;
    endcase

    // Beat count and error travel with the last beat, so completion follows its handshake.
    if (out_fire_s && out_last_q) begin
      comp_valid_d = 1'b1;
      comp_d.ch    = COMP_CH_MAX_W'(out_ch_q);
      comp_d.beats = COMP_CNT_MAX_W'(out_beats_q);
      comp_d.err   = out_err_q;
    end else begin
      comp_valid_d = 1'b0;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      gnt_q        <= '0;
      gnt_oh_q     <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      out_ch_q     <= '0;
      out_beats_q  <= '0;
      out_err_q    <= 1'b0;
      comp_valid_q <= 1'b0;
      comp_q       <= '0;
    end else begin
      state_q      <= state_d;
      gnt_q        <= gnt_d;
      gnt_oh_q     <= gnt_oh_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      out_ch_q     <= out_ch_d;
      out_beats_q  <= out_beats_d;
      out_err_q    <= out_err_d;
      comp_valid_q <= comp_valid_d;
      comp_q       <= comp_d;
    end
  end

  assign bus.host_ready = gnt_oh_q & {NUM_CH{ready_en_s}};
  assign bus.out_valid  = out_valid_q;
  assign bus.out_data   = out_data_q;
  assign bus.out_last   = out_last_q;
  assign bus.out_ch     = out_ch_q;
  assign bus.comp_valid = comp_valid_q;
  assign bus.comp_ch    = comp_q.ch[CH_W-1:0];
  assign bus.comp_beats = comp_q.beats[CNT_W-1:0];
  assign bus.comp_err   = comp_q.err;

  assign unused_comp_s = ^{comp_q.ch, comp_q.beats};

endmodule

// File: tb/tb_rdma_host_frame_mux.sv
// Directed bench: per-channel stimulus queues, a frame-level expectation model and
// one negedge monitor comparing every output handshake and completion.
module tb_rdma_host_frame_mux;
  localparam int NCH  = 4;
  localparam int DW   = 32;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rdma_host_frame_mux_if #(.NUM_CH(NCH), .DATA_W(DW), .MAX_BEATS(MAXB)) bus ();
  rdma_host_frame_mux #(.NUM_CH(NCH), .DATA_W(DW), .MAX_BEATS(MAXB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct { logic [DW-1:0] data; logic last; logic [1:0] ch; } beat_t;
  typedef struct { logic [1:0] ch; int beats; logic err; } comp_e_t;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  beat_t   exp_beats[$];
  comp_e_t exp_comps[$];
  comp_e_t seen_comps[$];
  int      hs_cyc[$];
  logic [DW+1:0] chq [NCH][$];  // bit DW+1: bubble, bit DW: last

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int ch, input int fid, input int b);
    return DW'((ch << 24) | (fid << 8) | b);
  endfunction

  task automatic send(input int ch, input int fid, input int len, input int bubble_after);
    for (int b = 0; b < len; b++) begin
      chq[ch].push_back({1'b0, (b == len - 1), mk(ch, fid, b)});
      if (b == bubble_after) chq[ch].push_back({1'b1, 1'b0, {DW{1'b0}}});
    end
  endtask

  // Model: only the first MAXB beats reach the output, the final one marked last.
  task automatic expect_frame(input int ch, input int fid, input int len);
    int n;
    beat_t bt;
    comp_e_t ce;
    n = (len > MAXB) ? MAXB : len;
    for (int b = 0; b < n; b++) begin
      bt.data = mk(ch, fid, b);
      bt.last = (b == n - 1);
      bt.ch   = 2'(ch);
      exp_beats.push_back(bt);
    end
    ce.ch = 2'(ch); ce.beats = n; ce.err = (len > MAXB);
    exp_comps.push_back(ce);
  endtask

  task automatic drive();
    logic [NCH-1:0] hv, hl;
    logic [NCH*DW-1:0] hd;
    hv = '0; hl = '0; hd = '0;
    for (int c = 0; c < NCH; c++) begin
      if (chq[c].size() > 0 && !chq[c][0][DW+1]) begin
        hv[c] = 1'b1;
        hl[c] = chq[c][0][DW];
        hd[c*DW +: DW] = chq[c][0][DW-1:0];
      end
    end
    bus.host_valid = hv;
    bus.host_last  = hl;
    bus.host_data  = hd;
  endtask

  task automatic step(output logic [NCH-1:0] acc);
    @(negedge clk);
    acc = rst ? '0 : (bus.host_valid & bus.host_ready);
    @(posedge clk);
    #1;
    for (int c = 0; c < NCH; c++) begin
      if (acc[c]) void'(chq[c].pop_front());
      else if (chq[c].size() > 0 && chq[c][0][DW+1]) void'(chq[c].pop_front());
    end
    drive();
  endtask

  function automatic bit busy_tb();
    bit b;
    b = (exp_beats.size() > 0) || (exp_comps.size() > 0);
    for (int c = 0; c < NCH; c++) if (chq[c].size() > 0) b = 1'b1;
    return b;
  endfunction

  task automatic run_until_done(input string name, input int budget);
    int n;
    logic [NCH-1:0] acc;
    n = 0;
    while (busy_tb() && n < budget) begin
      step(acc);
      n++;
    end
    checks++;
    if (busy_tb()) begin
      errors++;
      $display("FAIL %s_timeout: got %0d pending beats expected 0", name, exp_beats.size());
    end
    step(acc);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_host_ready"}, bus.host_ready, 0);
    check({tag, "_out_valid"},  bus.out_valid, 0);
    check({tag, "_out_last"},   bus.out_last, 0);
    check({tag, "_out_ch"},     bus.out_ch, 0);
    check({tag, "_out_data"},   bus.out_data, 0);
    check({tag, "_comp_valid"}, bus.comp_valid, 0);
    check({tag, "_comp_ch"},    bus.comp_ch, 0);
    check({tag, "_comp_beats"}, bus.comp_beats, 0);
    check({tag, "_comp_err"},   bus.comp_err, 0);
  endtask

  // Monitor: output beats, completions, stall stability, grant exclusivity.
  initial begin
    logic prev_stall, plast;
    logic [DW-1:0] pdata;
    logic [1:0] pch;
    int last_hs;
    beat_t eb;
    comp_e_t ec, sc;
    prev_stall = 1'b0; plast = 1'b0; pdata = '0; pch = '0; last_hs = -10;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("stall_valid", bus.out_valid, 1);
          check("stall_data", bus.out_data, pdata);
          check("stall_last", bus.out_last, plast);
          check("stall_ch", bus.out_ch, pch);
        end
        check("host_ready_onehot0", $onehot0(bus.host_ready), 1);
        if (bus.out_valid && bus.out_ready) begin
          hs_cyc.push_back(cyc);
          checks++;
          if (exp_beats.size() == 0) begin
            errors++;
            $display("FAIL out_beat_unexpected: got data %0h expected no beat", bus.out_data);
          end else begin
            eb = exp_beats.pop_front();
            check("out_data", bus.out_data, eb.data);
            check("out_last", bus.out_last, eb.last);
            check("out_ch", bus.out_ch, eb.ch);
          end
          if (bus.out_last) last_hs = cyc;
        end
        if (bus.comp_valid) begin
          check("comp_latency", cyc, last_hs + 1);
          sc.ch = bus.comp_ch; sc.beats = int'(bus.comp_beats); sc.err = bus.comp_err;
          seen_comps.push_back(sc);
          checks++;
          if (exp_comps.size() == 0) begin
            errors++;
            $display("FAIL comp_unexpected: got ch %0d expected no completion", bus.comp_ch);
          end else begin
            ec = exp_comps.pop_front();
            check("comp_ch", bus.comp_ch, ec.ch);
            check("comp_beats", bus.comp_beats, ec.beats);
            check("comp_err", bus.comp_err, ec.err);
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        pdata = bus.out_data; plast = bus.out_last; pch = bus.out_ch;
      end
    end
  end

  initial begin
    logic [NCH-1:0] acc;
    logic [DW-1:0] d0;
    bit found;
    int exp_gap[7];
    bus.out_ready = 1'b1;
    drive();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;

    // All four channels request 2-beat frames together: order 0,1,2,3 with one idle cycle.
    hs_cyc.delete();
    for (int c = 0; c < NCH; c++) begin
      send(c, 1, 2, -1);
      expect_frame(c, 1, 2);
    end
    drive();
    run_until_done("all4", 200);
    check("all4_hs_count", hs_cyc.size(), 8);
    exp_gap = '{1, 2, 1, 2, 1, 2, 1};
    for (int i = 0; i < 7; i++) begin
      if (hs_cyc.size() > i + 1) check("all4_hs_gap", hs_cyc[i+1] - hs_cyc[i], exp_gap[i]);
    end

    // Single 3-beat frame on ch2: each accepted beat is on the output one cycle later.
    send(2, 2, 3, -1);
    expect_frame(2, 2, 3);
    drive();
    for (int n = 0; n < 20 && chq[2].size() > 0; n++) begin
      d0 = chq[2][0][DW-1:0];
      step(acc);
      if (acc[2]) begin
        check("ch2_lat_valid", bus.out_valid, 1);
        check("ch2_lat_data", bus.out_data, d0);
        check("ch2_lat_ch", bus.out_ch, 2);
      end
    end
    run_until_done("ch2", 50);
    if (seen_comps.size() > 0) begin
      check("ch2_pin_ch", seen_comps[$].ch, 2);
      check("ch2_pin_beats", seen_comps[$].beats, 3);
      check("ch2_pin_err", seen_comps[$].err, 0);
    end

    // 4-beat frame (last on the MAX_BEATS-th beat) on ch0 with a 5-cycle stall after beat 1.
    send(0, 3, 4, -1);
    expect_frame(0, 3, 4);
    drive();
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      step(acc);
      if (bus.out_valid && bus.out_data[7:0] == 8'd1) found = 1'b1;
    end
    check("stall_reach_beat1", found, 1);
    bus.out_ready = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step(acc);
      check("stall_host_ready", bus.host_ready, 0);
    end
    bus.out_ready = 1'b1;
    run_until_done("stall", 50);
    if (seen_comps.size() > 0) begin
      check("maxlast_pin_beats", seen_comps[$].beats, 4);
      check("maxlast_pin_err", seen_comps[$].err, 0);
    end

    // 7-beat frame on ch1 truncated to 4; ch3 arrives mid-frame and must wait for input last.
    send(1, 4, 7, -1);
    expect_frame(1, 4, 7);
    drive();
    repeat (3) step(acc);
    send(3, 5, 2, -1);
    expect_frame(3, 5, 2);
    drive();
    run_until_done("trunc", 100);
    if (seen_comps.size() > 1) begin
      check("trunc_pin_ch", seen_comps[$-1].ch, 1);
      check("trunc_pin_beats", seen_comps[$-1].beats, 4);
      check("trunc_pin_err", seen_comps[$-1].err, 1);
    end

    // ch1 drops valid mid-frame while ch0 requests: the frame stays locked to ch1.
    send(1, 6, 3, 0);
    expect_frame(1, 6, 3);
    expect_frame(0, 7, 1);
    drive();
    repeat (2) step(acc);
    send(0, 7, 1, -1);
    drive();
    run_until_done("lock", 60);
    if (seen_comps.size() > 0) check("single_pin_beats", seen_comps[$].beats, 1);

    // Reset during beat 2 of a 5-beat frame: everything dropped, then ch3 completes.
    send(0, 8, 5, -1);
    drive();
    repeat (2) step(acc);
    rst = 1'b1;
    step(acc);
    check_reset_outputs("rst_mid");
    rst = 1'b0;
    chq[0].delete();
    drive();
    repeat (4) step(acc);
    send(3, 9, 2, -1);
    expect_frame(3, 9, 2);
    drive();
    run_until_done("post_rst", 50);
    check("final_exp_beats_empty", exp_beats.size(), 0);
    check("final_exp_comps_empty", exp_comps.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
